// File: rtl/dense_accumulate_cell.sv
// rtl/dense_accumulate_cell.sv - multiply-accumulate cell emitting one dot-product sum per neuron
//
// Purpose: accepts a stream of value/weight terms, sums INPUT_AMOUNT products per
// neuron and emits each neuron's sum with its index; WEIGHT_AMOUNT neurons form a frame.
// Optional feature macro: DENSE_ACCUMULATE_SATURATE_EN (saturating arithmetic;
// default build truncates products and wraps sums).
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   input_value   unsigned feature operand
//   input_weight  unsigned weight operand
//   input_enable  term valid this cycle
//   input_ready   term can be accepted this cycle (combinational from state)
//   output_index  index of the neuron being emitted
//   output_value  accumulated sum of that neuron
//   output_enable one-cycle pulse per emitted neuron
//   frame_done    pulse coincident with emission of the last neuron index
module dense_accumulate_cell #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int INPUT_AMOUNT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_value,
  input  logic [DATA_WIDTH-1:0] input_weight,
  input  logic                  input_enable,
  output logic                  input_ready,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic                  output_enable,
  output logic                  frame_done
);

  localparam int TW = (INPUT_AMOUNT > 1) ? $clog2(INPUT_AMOUNT) : 1;
  localparam logic [TW-1:0]         LAST_TERM   = TW'(INPUT_AMOUNT - 1);
  localparam logic [DATA_WIDTH-1:0] LAST_NEURON = DATA_WIDTH'(WEIGHT_AMOUNT - 1);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] accumulator;
  logic [DATA_WIDTH-1:0] neuron_count;
  logic [TW-1:0]         term_count;
  logic [DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0] sum;
  logic                  accept;

  // Ready is forced low during reset so terms presented then are dropped.
  assign input_ready = (state == ACCUM) && !rst;
  assign accept      = input_enable && input_ready;

`ifdef DENSE_ACCUMULATE_SATURATE_EN
  logic [2*DATA_WIDTH-1:0] full_product;
  logic [DATA_WIDTH:0]     wide_sum;

  assign full_product = {{DATA_WIDTH{1'b0}}, input_value} * {{DATA_WIDTH{1'b0}}, input_weight};
  // Any bit above the data width means the product does not fit: clamp.
  assign product  = (|full_product[2*DATA_WIDTH-1:DATA_WIDTH]) ? '1 : full_product[DATA_WIDTH-1:0];
  assign wide_sum = {1'b0, accumulator} + {1'b0, product};
  // Carry out clamps; an accumulator already at all-ones stays there.
  assign sum      = wide_sum[DATA_WIDTH] ? '1 : wide_sum[DATA_WIDTH-1:0];
`else
  // Same-width multiply keeps only the low DATA_WIDTH bits; sum wraps.
  assign product = input_value * input_weight;
  assign sum     = accumulator + product;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      accumulator   <= '0;
      term_count    <= '0;
      neuron_count  <= '0;
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          output_enable <= 1'b0;
          frame_done    <= 1'b0;
          if (accept) begin
            if (term_count == LAST_TERM) begin
              output_value  <= sum;
              output_index  <= neuron_count;
              output_enable <= 1'b1;
              frame_done    <= (neuron_count == LAST_NEURON);
              accumulator   <= '0;
              term_count    <= '0;
              state         <= EMIT;
            end else begin
              accumulator <= sum;
              term_count  <= term_count + TW'(1);
            end
          end
        end
        EMIT: begin
          output_enable <= 1'b0;
          frame_done    <= 1'b0;
          neuron_count  <= (neuron_count == LAST_NEURON) ? '0 : neuron_count + DATA_WIDTH'(1);
          state         <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_accumulate_cell.sv
// tb/tb_dense_accumulate_cell.sv - scoreboard bench for dense_accumulate_cell
module tb_dense_accumulate_cell;

  localparam int DW = 32;
  localparam int WA = 4;
  localparam int IA = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] input_value, input_weight;
  logic          input_enable;
  logic          input_ready;
  logic [DW-1:0] output_index, output_value;
  logic          output_enable, frame_done;

  logic          rst8, en8, ready8, oe8, fd8;
  logic [7:0]    v8, w8, idx8, val8;

  always #5 clk = ~clk;

  dense_accumulate_cell #(.DATA_WIDTH(DW), .WEIGHT_AMOUNT(WA), .INPUT_AMOUNT(IA)) u_dut (
    .clk(clk), .rst(rst), .input_value(input_value), .input_weight(input_weight),
    .input_enable(input_enable), .input_ready(input_ready), .output_index(output_index),
    .output_value(output_value), .output_enable(output_enable), .frame_done(frame_done)
  );

  dense_accumulate_cell #(.DATA_WIDTH(8), .WEIGHT_AMOUNT(4), .INPUT_AMOUNT(2)) u_dut8 (
    .clk(clk), .rst(rst8), .input_value(v8), .input_weight(w8),
    .input_enable(en8), .input_ready(ready8), .output_index(idx8),
    .output_value(val8), .output_enable(oe8), .frame_done(fd8)
  );

  typedef struct {
    logic [DW-1:0] idx;
    logic [DW-1:0] val;
    logic          fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input bit ok, input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic: true mathematical sum, reduced once to the output width.
  // Clamping each product and the running sum is equivalent to clamping the total
  // because every term is non-negative.
  function automatic logic [95:0] reduce(input logic [95:0] s, input int width);
    logic [95:0] max_v;
    max_v = (96'd1 << width) - 96'd1;
`ifdef DENSE_ACCUMULATE_SATURATE_EN
    return (s > max_v) ? max_v : s;
`else
    return s & max_v;
`endif
  endfunction

  // Model state: terms collected, true sum, next neuron index, emission cycle pending.
  int          m_terms = 0;
  logic [95:0] m_sum = '0;
  int          m_idx = 0;
  bit          m_busy = 1'b0;

  task automatic step(input bit en, input logic [DW-1:0] v, input logic [DW-1:0] w, input bit r);
    exp_t e;
    rst = r;
    input_enable = en;
    input_value = v;
    input_weight = w;
    #0;
    check(input_ready == (!r && !m_busy), "input_ready", 96'(input_ready), 96'(!r && !m_busy));
    @(posedge clk);
    if (r) begin
      m_terms = 0; m_sum = '0; m_idx = 0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_busy = 1'b0;
    end else if (en) begin
      m_sum = m_sum + 96'(v) * 96'(w);
      m_terms++;
      if (m_terms == IA) begin
        e.idx = DW'(m_idx);
        e.val = DW'(reduce(m_sum, DW));
        e.fd  = (m_idx == WA - 1);
        q.push_back(e);
        m_idx = (m_idx + 1) % WA;
        m_terms = 0;
        m_sum = '0;
        m_busy = 1'b1;
      end
    end
    #1;
  endtask

  task automatic neuron(input logic [DW-1:0] v0, input logic [DW-1:0] w0,
                        input logic [DW-1:0] v1, input logic [DW-1:0] w1);
    step(1'b1, v0, w0, 1'b0);
    step(1'b1, v1, w1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: reset state, scoreboard pops on each emission, hold between emissions.
  logic          rst_q = 1'b1;
  logic [DW-1:0] last_idx = '0, last_val = '0;

  always @(posedge clk) rst_q = rst;

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      check(output_enable == 1'b0 && frame_done == 1'b0, "reset_flags",
            96'({output_enable, frame_done}), 96'd0);
      check(output_index == '0 && output_value == '0, "reset_data",
            96'({output_index, output_value}), 96'd0);
      last_idx = '0;
      last_val = '0;
    end else if (output_enable) begin
      check(input_ready == 1'b0, "ready_in_emit", 96'(input_ready), 96'd0);
      if (q.size() == 0) begin
        check(1'b0, "unexpected_emit", 96'(output_index), 96'd0);
      end else begin
        e = q.pop_front();
        check(output_index == e.idx, "emit_index", 96'(output_index), 96'(e.idx));
        check(output_value == e.val, "emit_value", 96'(output_value), 96'(e.val));
        check(frame_done == e.fd, "frame_done", 96'(frame_done), 96'(e.fd));
      end
      last_idx = output_index;
      last_val = output_value;
    end else begin
      check(frame_done == 1'b0, "frame_done_idle", 96'(frame_done), 96'd0);
      check(output_index == last_idx && output_value == last_val, "hold_outputs",
            96'(output_value), 96'(last_val));
    end
  end

  initial begin
    logic [95:0] exp8;
    int          waited;
    bit          seen;
    rst = 1'b1; input_enable = 1'b0; input_value = '0; input_weight = '0;
    rst8 = 1'b1; en8 = 1'b0; v8 = '0; w8 = '0;
    @(posedge clk); #1;

    // Terms presented during reset are discarded.
    step(1'b1, 32'd9, 32'd9, 1'b1);
    step(1'b1, 32'd9, 32'd9, 1'b1);

    // (3,4),(5,6) back-to-back -> index 0, value 42.
    neuron(32'd3, 32'd4, 32'd5, 32'd6);
    step(1'b0, 32'd0, 32'd0, 1'b1);

    // Sums 10,20,30,40 then a fifth neuron wrapping to index 0.
    neuron(32'd2, 32'd5, 32'd0, 32'd0);
    neuron(32'd4, 32'd5, 32'd0, 32'd0);
    neuron(32'd5, 32'd6, 32'd0, 32'd0);
    neuron(32'd8, 32'd5, 32'd0, 32'd0);
    neuron(32'd1, 32'd1, 32'd1, 32'd1);

    // Enable held through EMIT with (100,100): that term must be dropped.
    step(1'b1, 32'd2, 32'd3, 1'b0);
    step(1'b1, 32'd4, 32'd5, 1'b0);
    step(1'b1, 32'd100, 32'd100, 1'b0);
    step(1'b1, 32'd1, 32'd1, 1'b0);
    step(1'b1, 32'd2, 32'd2, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0);

    // Reset mid-neuron drops (7,7); next emission is index 0 value 14.
    step(1'b1, 32'd7, 32'd7, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    neuron(32'd1, 32'd2, 32'd3, 32'd4);

    // Five idle cycles between the two terms.
    step(1'b1, 32'd3, 32'd4, 1'b0);
    repeat (5) step(1'b0, 32'd77, 32'd77, 1'b0);
    step(1'b1, 32'd5, 32'd6, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0);

    // Randomised traffic with overflowing operands and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] v, w;
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom; w = $urandom;
      end else begin
        v = $urandom_range(0, 255); w = $urandom_range(0, 255);
      end
      step($urandom_range(0, 3) != 0, v, w, $urandom_range(0, 39) == 0);
    end
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0);
    check(q.size() == 0, "queue_drain", 96'(q.size()), 96'd0);

    // Narrow instance: (16,16),(200,1) exercises product and sum overflow.
    @(posedge clk); #1;
    rst8 = 1'b0; en8 = 1'b1; v8 = 8'd16; w8 = 8'd16;
    @(posedge clk); #1;
    v8 = 8'd200; w8 = 8'd1;
    @(posedge clk); #1;
    en8 = 1'b0;
    exp8 = reduce(96'd16 * 96'd16 + 96'd200, 8);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 10) begin
      if (oe8) begin
        seen = 1'b1;
        check(waited == 0, "narrow_latency", 96'(waited), 96'd0);
        check(val8 == exp8[7:0], "narrow_value", 96'(val8), exp8);
        check(idx8 == 8'd0, "narrow_index", 96'(idx8), 96'd0);
        check(ready8 == 1'b0, "narrow_ready", 96'(ready8), 96'd0);
      end else begin
        @(posedge clk); #1;
        waited++;
      end
    end
    if (!seen) check(1'b0, "narrow_timeout", 96'(waited), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
